// File: rtl/mandelbrot_rendering_engine.sv
// Mandelbrot escape-iteration engine: walks a frame in raster order and runs one
// Q4.12 iteration per clock. Each pixel's {x, y, iter} word is handed out through
// a one-deep ready/send_data holding register.
module mandelbrot_rendering_engine #(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int MAX_ITER = 255,
  parameter int X_MIN    = -8192,
  parameter int Y_MIN    = -5120,
  parameter int STEP     = 77
) (
  input  logic        CLK,
  input  logic        nreset,
  input  logic        start_render,
  input  logic        send_data,
  output logic [31:0] data,
  output logic        ready,
  output logic        frame_ready
);

  localparam logic [11:0] XLast   = 12'(H_RES - 1);
  localparam logic [11:0] YLast   = 12'(V_RES - 1);
  localparam logic [7:0]  IterCap = 8'(MAX_ITER);

  typedef enum logic [1:0] {StIdle, StInit, StIterate, StHold} state_e;

  state_e             state_q, state_d;
  logic        [11:0] x_q, x_d, y_q, y_d;
  logic signed [15:0] zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
  logic        [7:0]  iter_q, iter_d;
  logic        [31:0] data_q, data_d;
  logic               ready_q, ready_d, frame_ready_q, frame_ready_d;

  // 32-bit datapath: sign-extended operands, full products, fixed-point rescale
  logic signed [31:0] zr_w, zi_w, zr_sq, zi_sq, zri2, mag, re_sh, im_sh;
  logic signed [31:0] cr_full, ci_full;
  logic signed [15:0] zr_nx, zi_nx;
  logic               escape;

  assign zr_w    = $signed({{16{zr_q[15]}}, zr_q});
  assign zi_w    = $signed({{16{zi_q[15]}}, zi_q});
  assign zr_sq   = zr_w * zr_w;
  assign zi_sq   = zi_w * zi_w;
  assign zri2    = (zr_w * zi_w) <<< 1;
  assign mag     = (zr_sq + zi_sq) >>> 12;
  assign re_sh   = (zr_sq - zi_sq) >>> 12;
  assign im_sh   = zri2 >>> 12;
  assign zr_nx   = re_sh[15:0] + cr_q;
  assign zi_nx   = im_sh[15:0] + ci_q;
  assign cr_full = X_MIN + $signed({20'd0, x_q}) * STEP;
  assign ci_full = Y_MIN + $signed({20'd0, y_q}) * STEP;
  // Escape test looks at z before this cycle's update
  assign escape  = (mag >= 32'sd16384) || (iter_q == IterCap);

  // Next-state and datapath control
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    zr_d          = zr_q;
    zi_d          = zi_q;
    cr_d          = cr_q;
    ci_d          = ci_q;
    iter_d        = iter_q;
    data_d        = data_q;
    ready_d       = ready_q;
    frame_ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_render) begin
          x_d     = '0;
          y_d     = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        zr_d    = '0;
        zi_d    = '0;
        iter_d  = '0;
        cr_d    = cr_full[15:0];
        ci_d    = ci_full[15:0];
        state_d = StIterate;
      end
      StIterate: begin
        if (escape) begin
          data_d  = {x_q, y_q, iter_q};
          ready_d = 1'b1;
          state_d = StHold;
        end else begin
          zr_d   = zr_nx;
          zi_d   = zi_nx;
          iter_d = iter_q + 8'd1;
        end
      end
      StHold: begin
        if (send_data) begin
          ready_d = 1'b0;
          if (x_q == XLast && y_q == YLast) begin
            frame_ready_d = 1'b1;
            x_d           = '0;
            y_d           = '0;
            state_d       = StIdle;
          end else begin
            if (x_q == XLast) begin
              x_d = '0;
              y_d = y_q + 12'd1;
            end else begin
              x_d = x_q + 12'd1;
            end
            state_d = StInit;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      zr_q          <= '0;
      zi_q          <= '0;
      cr_q          <= '0;
      ci_q          <= '0;
      iter_q        <= '0;
      data_q        <= '0;
      ready_q       <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      zr_q          <= zr_d;
      zi_q          <= zi_d;
      cr_q          <= cr_d;
      ci_q          <= ci_d;
      iter_q        <= iter_d;
      data_q        <= data_d;
      ready_q       <= ready_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign data        = data_q;
  assign ready       = ready_q;
  assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_mandelbrot_rendering_engine.sv
// Directed bench for mandelbrot_rendering_engine using four parameterisations:
// 0 default frame, 1 single pixel at c=0, 2 4x2 frame, 3 4x1 line on the real axis.
module tb_mandelbrot_rendering_engine;

  logic        CLK = 1'b0;
  logic        nreset = 1'b0;
  logic [3:0]  start = '0;
  logic [3:0]  send = '0;
  logic [3:0]  ready;
  logic [3:0]  fr;
  logic [31:0] dat [4];

  int cmp_cnt = 0;
  int err_cnt = 0;
  int fr_cnt [4] = '{0, 0, 0, 0};

  always #5 CLK = ~CLK;

  mandelbrot_rendering_engine u_a (
    .CLK(CLK), .nreset(nreset), .start_render(start[0]), .send_data(send[0]),
    .data(dat[0]), .ready(ready[0]), .frame_ready(fr[0])
  );
  mandelbrot_rendering_engine #(
    .H_RES(1), .V_RES(1), .MAX_ITER(255), .X_MIN(0), .Y_MIN(0), .STEP(0)
  ) u_b (
    .CLK(CLK), .nreset(nreset), .start_render(start[1]), .send_data(send[1]),
    .data(dat[1]), .ready(ready[1]), .frame_ready(fr[1])
  );
  mandelbrot_rendering_engine #(
    .H_RES(4), .V_RES(2)
  ) u_c (
    .CLK(CLK), .nreset(nreset), .start_render(start[2]), .send_data(send[2]),
    .data(dat[2]), .ready(ready[2]), .frame_ready(fr[2])
  );
  mandelbrot_rendering_engine #(
    .H_RES(4), .V_RES(1), .MAX_ITER(255), .X_MIN(-4096), .Y_MIN(0), .STEP(2048)
  ) u_d (
    .CLK(CLK), .nreset(nreset), .start_render(start[3]), .send_data(send[3]),
    .data(dat[3]), .ready(ready[3]), .frame_ready(fr[3])
  );

  // Count frame_ready pulses per instance
  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) if (fr[i]) fr_cnt[i] <= fr_cnt[i] + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts edges (the first being the start/accept edge) until ready is seen high.
  task automatic wait_word(input int i, input bit keep, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 400) begin
      @(posedge CLK);
      #1;
      lat++;
      start[i] = 1'b0;
      if (!keep) send[i] = 1'b0;
      ok = ready[i];
    end
  endtask

  typedef struct {
    int          inst;
    logic [31:0] exp_data;
    int          exp_lat;
    bit          last;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int   lat;
    bit   ok;
    int   bad;
    vec_t v;

    // Instance 2: 4x2 frame near c=(-2,-1.25); every pixel escapes after one update
    vecs[0]  = '{2, 32'h0000_0001, 4, 1'b0};
    vecs[1]  = '{2, 32'h0010_0001, 4, 1'b0};
    vecs[2]  = '{2, 32'h0020_0001, 4, 1'b0};
    vecs[3]  = '{2, 32'h0030_0001, 4, 1'b0};
    vecs[4]  = '{2, 32'h0000_0101, 4, 1'b0};
    vecs[5]  = '{2, 32'h0010_0101, 4, 1'b0};
    vecs[6]  = '{2, 32'h0020_0101, 4, 1'b0};
    vecs[7]  = '{2, 32'h0030_0101, 4, 1'b1};
    // Instance 3: c = -1, -0.5, 0 stay bounded; c = +0.5 escapes after 5 updates
    vecs[8]  = '{3, 32'h0000_00FF, 258, 1'b0};
    vecs[9]  = '{3, 32'h0010_00FF, 258, 1'b0};
    vecs[10] = '{3, 32'h0020_00FF, 258, 1'b0};
    vecs[11] = '{3, 32'h0030_0005, 8, 1'b1};

    // Reset held with the clock running
    repeat (5) @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd0);
      chk($sformatf("rst_frame_ready%0d", i), 32'(fr[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), dat[i], 32'd0);
    end
    nreset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(posedge CLK);
      #1;
      if (ready != 4'd0) bad++;
    end
    chk("idle_no_ready", 32'(bad), 32'd0);

    // Single non-escaping pixel hits the iteration cap
    start[1] = 1'b1;
    wait_word(1, 1'b0, lat, ok);
    chk("b_ready_seen", 32'(ok), 32'd1);
    chk("b_data", dat[1], 32'h0000_00FF);
    chk("b_latency", 32'(lat), 32'd258);
    send[1] = 1'b1;
    @(posedge CLK);
    #1;
    send[1] = 1'b0;
    chk("b_frame_ready", 32'(fr[1]), 32'd1);
    chk("b_ready_drop", 32'(ready[1]), 32'd0);
    @(posedge CLK);
    #1;
    chk("b_frame_ready_pulse", 32'(fr[1]), 32'd0);

    // Table-driven frames: instance 2 with send held high, instance 3 handshaking
    for (int k = 0; k < 12; k++) begin
      v = vecs[k];
      if (k == 0 || vecs[k-1].inst != v.inst) begin
        send[v.inst]  = (v.inst == 2);
        start[v.inst] = 1'b1;
      end else if (v.inst != 2) begin
        send[v.inst] = 1'b1;
      end
      wait_word(v.inst, v.inst == 2, lat, ok);
      chk($sformatf("vec%0d_ready_seen", k), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_data", k), dat[v.inst], v.exp_data);
      chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(v.exp_lat));
      if (v.last) begin
        send[v.inst] = 1'b1;
        @(posedge CLK);
        #1;
        send[v.inst] = 1'b0;
        chk($sformatf("vec%0d_frame_ready", k), 32'(fr[v.inst]), 32'd1);
        chk($sformatf("vec%0d_ready_drop", k), 32'(ready[v.inst]), 32'd0);
        @(posedge CLK);
        #1;
        chk($sformatf("vec%0d_frame_ready_pulse", k), 32'(fr[v.inst]), 32'd0);
      end
    end
    bad = 0;
    repeat (10) begin
      @(posedge CLK);
      #1;
      if (ready != 4'd0) bad++;
    end
    chk("frames_idle_after", 32'(bad), 32'd0);
    chk("c_frame_ready_count", 32'(fr_cnt[2]), 32'd1);
    chk("d_frame_ready_count", 32'(fr_cnt[3]), 32'd1);

    // Default frame: first pixel escapes after one update
    start[0] = 1'b1;
    wait_word(0, 1'b0, lat, ok);
    chk("a_ready_seen", 32'(ok), 32'd1);
    chk("a_first_data", dat[0], 32'h0000_0001);
    chk("a_first_latency", 32'(lat), 32'd4);

    // Backpressure, with a stray start_render that must be ignored
    bad = 0;
    for (int j = 0; j < 50; j++) begin
      @(posedge CLK);
      #1;
      if (dat[0] !== 32'h0000_0001 || ready[0] !== 1'b1) bad++;
      start[0] = (j == 20);
    end
    start[0] = 1'b0;
    chk("a_backpressure_hold", 32'(bad), 32'd0);
    send[0] = 1'b1;
    wait_word(0, 1'b0, lat, ok);
    chk("a_pix1_data", dat[0], 32'h0010_0001);
    chk("a_pix1_latency", 32'(lat), 32'd4);
    send[0] = 1'b1;
    wait_word(0, 1'b0, lat, ok);
    chk("a_pix2_data", dat[0], 32'h0020_0001);

    // Accept pixel 2, then reset while pixel 3 iterates
    send[0] = 1'b1;
    @(posedge CLK);
    #1;
    send[0] = 1'b0;
    @(posedge CLK);
    #2;
    nreset = 1'b0;
    #1;
    chk("a_midreset_ready", 32'(ready[0]), 32'd0);
    chk("a_midreset_data", dat[0], 32'd0);
    chk("a_midreset_frame_ready", 32'(fr[0]), 32'd0);
    @(posedge CLK);
    #1;
    nreset = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge CLK);
      #1;
      if (ready[0]) bad++;
    end
    chk("a_no_output_after_reset", 32'(bad), 32'd0);
    start[0] = 1'b1;
    wait_word(0, 1'b0, lat, ok);
    chk("a_restart_data", dat[0], 32'h0000_0001);
    chk("a_restart_latency", 32'(lat), 32'd4);

    // Reset while a word is held: must clear without a clock edge
    #1;
    nreset = 1'b0;
    #1;
    chk("a_async_clear_ready", 32'(ready[0]), 32'd0);
    chk("a_async_clear_data", dat[0], 32'd0);
    @(posedge CLK);
    #1;
    nreset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mandelbrot_rendering_engine.md
Name: mandelbrot_rendering_engine

Overview:
- Computes Mandelbrot escape-iteration counts for each pixel of a fixed-size frame, in raster order, one fixed-point iteration per clock.
- Streams one 32-bit result word per pixel to the frame-buffer write controller through a ready/send_data handshake.
- Pulses frame_ready when the last pixel of the frame has been consumed.
- Sits between the top-level controller and the DDR2 video RAM write path, all in the clk0 domain.

Parameters:
- H_RES, 160: pixels per line (max 4095).
- V_RES, 120: lines per frame (max 4095).
- MAX_ITER, 255: iteration cap (max 255).
- X_MIN, -8192: real coordinate of column 0, signed Q4.12 (-2.0).
- Y_MIN, -5120: imaginary coordinate of line 0, signed Q4.12 (-1.25).
- STEP, 77: coordinate increment per pixel/line, Q4.12.

Ports:
- CLK  in  1  rising-edge clock.
- nreset  in  1  asynchronous active-low reset.
- start_render  in  1  starts a frame when sampled high in IDLE; ignored otherwise.
- send_data  in  1  consumer accept; a word transfers on an edge where ready && send_data.
- data  out  32  result word: [31:20] = x, [19:8] = y, [7:0] = iteration count.
- ready  out  1  data holds a valid, unconsumed result.
- frame_ready  out  1  one-cycle pulse after the final pixel of a frame is consumed.

Behaviour:
- Reset (nreset low, asynchronous): state=IDLE; ready=0, frame_ready=0, data=0; x=y=0; z and iteration regs cleared.
- Arithmetic:
  - Signed 16-bit Q4.12 values.
  - Products are 32-bit, arithmetic-shifted right 12 and truncated to 16 bits.
  - cr = X_MIN + x*STEP; ci = Y_MIN + y*STEP; computed in 32 bits, truncated to 16.
- State IDLE: on start_render=1 → INIT with x=y=0.
- State INIT: zr=zi=0, iter=0, load cr/ci for the current x,y → ITERATE.
- State ITERATE, once per cycle:
  - Compute m = (zr*zr + zi*zi)>>>12 from the current z.
  - If m >= 16384 (|z|^2 >= 4.0) or iter == MAX_ITER: latch data={x,y,iter}, set ready=1 → HOLD.
  - Else: zr <= ((zr*zr - zi*zi)>>>12) + cr; zi <= ((2*zr*zi)>>>12) + ci; iter <= iter+1.
  - Escape check uses pre-update z. Iteration count = number of updates performed.
- State HOLD:
  - data and ready are held stable until send_data=1.
  - On the accepting edge: ready <= 0 and the pixel advances. x+1; when x==H_RES-1, x wraps to 0 and y+1.
  - If the consumed pixel was (H_RES-1, V_RES-1): frame_ready <= 1 for exactly one cycle, x=y=0 → IDLE.
  - Otherwise → INIT.
- Latency: pixel result has ready high exactly iter+3 rising edges after the edge that samples start_render, or that accepts the previous word.
- One-deep output: at most one word per pixel-compute. ready never high in IDLE, INIT or ITERATE.
- send_data while ready=0: no effect.
- start_render outside IDLE: ignored; the frame in progress is not restarted.
- start_render on the same edge frame_ready asserts: ignored, since the state is not yet IDLE.
- Reset mid-frame: aborts immediately. After release, no output until a new start_render.

Test Plan:
- Reset check: hold nreset low with CLK running → ready=0, frame_ready=0, data=0. Release, no start_render for 100 cycles → ready stays 0.
- Escape at first pixel: defaults, pulse start_render → pixel (0,0), c=(-2.0,-1.25), |c|^2=5.5625 → data=0x0000_0001, ready rises 4 edges after start is sampled.
- Non-escaping point: X_MIN=0, Y_MIN=0, STEP=0, H_RES=V_RES=1 → data=0x0000_00FF after 258 edges. frame_ready pulses one cycle after send_data accepted; state returns to IDLE.
- Full frame: H_RES=4, V_RES=2, send_data held high → exactly 8 words, x/y order (0,0),(1,0)..(3,0),(0,1)..(3,1). Single frame_ready pulse after 8th accept.
- Backpressure: hold send_data low 50 cycles while ready=1 → data unchanged, no advance. Raise send_data → ready drops next edge, next pixel follows.
- Reset mid-frame: assert nreset during ITERATE of pixel 3 → ready=0 immediately. A new start_render after release restarts at pixel (0,0).
